// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : wb_arbiter_pkg                                               |
// | Purpose : Shared writeback-path types, field widths and helpers used   |
// |           by the writeback arbiter and its round-robin picker.         |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package wb_arbiter_pkg;

  localparam int c_PC_BITS        = 32;
  localparam int c_AREG_BITS      = 5;
  localparam int c_DATA_BITS      = 32;
  localparam int c_SEQ_NUM_BITS   = 5;
  localparam int c_PHYS_ADDR_BITS = 6;

  // X->W message at the default machine widths.
  typedef struct packed {
    logic [c_PC_BITS-1:0]        pc;
    logic [c_SEQ_NUM_BITS-1:0]   seq_num;
    logic [c_AREG_BITS-1:0]      waddr;
    logic [c_DATA_BITS-1:0]      wdata;
    logic                        wen;
    logic [c_PHYS_ADDR_BITS-1:0] preg;
    logic [c_PHYS_ADDR_BITS-1:0] ppreg;
  } xw_msg_t;

  // Round-robin successor of idx among n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                   |
// | Purpose : Combinational round-robin priority picker. Scans requests    |
// |           from i_ptr upward (modulo NUM_REQ); first request wins.      |
// | Ports   : i_req   [NUM_REQ]  request vector                            |
// |           i_ptr   [IDX_BITS] highest-priority slot                     |
// |           o_grant [NUM_REQ]  one-hot grant (zero if no request)        |
// |           o_idx   [IDX_BITS] encoded winner (0 if no request)          |
// |           o_any   1          some request present                      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDX_BITS-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [IDX_BITS-1:0] o_idx,
  output logic                o_any
);

  logic [IDX_BITS:0]   w_sum;
  logic [IDX_BITS-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit so ptr+k cannot overflow before the modulo fold.
      w_sum = {1'b0, i_ptr} + (IDX_BITS+1)'(k);
      if (w_sum >= (IDX_BITS+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_BITS+1)'(NUM_REQ);
      end
      w_pos = w_sum[IDX_BITS-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        o_any          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : wb_arbiter                                                   |
// | Purpose : Shares the single X->W writeback port among NUM_UNITS        |
// |           execute units using round-robin priority, capturing the      |
// |           winner in a one-entry output register.                       |
// | Ports   : clk, rst (async, active-high)                                |
// |           i_x_val/o_x_rdy      per-unit handshake                      |
// |           i_x_pc .. i_x_ppreg  per-unit message fields                 |
// |           o_w_val/i_w_rdy      writeback handshake                     |
// |           o_w_pc .. o_w_ppreg  registered winning message              |
// |           o_w_unit             unit that produced the current output   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int SEQ_NUM_BITS   = c_SEQ_NUM_BITS,
  parameter int PHYS_ADDR_BITS = c_PHYS_ADDR_BITS
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_UNITS-1:0]                      i_x_val,
  output logic [NUM_UNITS-1:0]                      o_x_rdy,
  input  logic [NUM_UNITS-1:0][c_PC_BITS-1:0]       i_x_pc,
  input  logic [NUM_UNITS-1:0][SEQ_NUM_BITS-1:0]    i_x_seq_num,
  input  logic [NUM_UNITS-1:0][c_AREG_BITS-1:0]     i_x_waddr,
  input  logic [NUM_UNITS-1:0][c_DATA_BITS-1:0]     i_x_wdata,
  input  logic [NUM_UNITS-1:0]                      i_x_wen,
  input  logic [NUM_UNITS-1:0][PHYS_ADDR_BITS-1:0]  i_x_preg,
  input  logic [NUM_UNITS-1:0][PHYS_ADDR_BITS-1:0]  i_x_ppreg,
  output logic                                      o_w_val,
  input  logic                                      i_w_rdy,
  output logic [c_PC_BITS-1:0]                      o_w_pc,
  output logic [SEQ_NUM_BITS-1:0]                   o_w_seq_num,
  output logic [c_AREG_BITS-1:0]                    o_w_waddr,
  output logic [c_DATA_BITS-1:0]                    o_w_wdata,
  output logic                                      o_w_wen,
  output logic [PHYS_ADDR_BITS-1:0]                 o_w_preg,
  output logic [PHYS_ADDR_BITS-1:0]                 o_w_ppreg,
  output logic [$clog2(NUM_UNITS)-1:0]              o_w_unit
);

  localparam int c_IDX_BITS = $clog2(NUM_UNITS);

  // Message layout at this instance's widths.
  typedef struct packed {
    logic [c_PC_BITS-1:0]      pc;
    logic [SEQ_NUM_BITS-1:0]   seq_num;
    logic [c_AREG_BITS-1:0]    waddr;
    logic [c_DATA_BITS-1:0]    wdata;
    logic                      wen;
    logic [PHYS_ADDR_BITS-1:0] preg;
    logic [PHYS_ADDR_BITS-1:0] ppreg;
  } msg_t;

  logic [c_IDX_BITS-1:0] r_rr_ptr;
  logic                  r_w_val;
  logic [c_IDX_BITS-1:0] r_w_unit;
  msg_t                  r_msg;

  logic [NUM_UNITS-1:0]  w_grant;
  logic [c_IDX_BITS-1:0] w_idx;
  logic                  w_any;
  logic                  w_accept;
  logic                  w_xfer;
  msg_t                  w_sel;

  rr_arbiter #(
    .NUM_REQ  (NUM_UNITS),
    .IDX_BITS (c_IDX_BITS)
  ) u_rr_arbiter (
    .i_req   (i_x_val),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Output slot is empty or being drained this cycle.
  assign w_accept = !r_w_val || i_w_rdy;
  assign w_xfer   = w_accept && w_any;
  assign o_x_rdy  = w_accept ? w_grant : '0;

  always_comb begin
    w_sel         = '0;
    w_sel.pc      = i_x_pc[w_idx];
    w_sel.seq_num = i_x_seq_num[w_idx];
    w_sel.waddr   = i_x_waddr[w_idx];
    w_sel.wdata   = i_x_wdata[w_idx];
    w_sel.wen     = i_x_wen[w_idx];
    w_sel.preg    = i_x_preg[w_idx];
    w_sel.ppreg   = i_x_ppreg[w_idx];
  end

  // A transfer overrides a simultaneous drain, so back-to-back messages
  // keep w_val high. Payload is only ever loaded, never cleared, outside reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_w_val  <= 1'b0;
      r_w_unit <= '0;
      r_msg    <= '0;
    end else if (w_xfer) begin
      r_w_val  <= 1'b1;
      r_w_unit <= w_idx;
      r_msg    <= w_sel;
      r_rr_ptr <= c_IDX_BITS'(rr_next(int'(w_idx), NUM_UNITS));
    end else if (i_w_rdy) begin
      r_w_val  <= 1'b0;
    end
  end

  assign o_w_val     = r_w_val;
  assign o_w_unit    = r_w_unit;
  assign o_w_pc      = r_msg.pc;
  assign o_w_seq_num = r_msg.seq_num;
  assign o_w_waddr   = r_msg.waddr;
  assign o_w_wdata   = r_msg.wdata;
  assign o_w_wen     = r_msg.wen;
  assign o_w_preg    = r_msg.preg;
  assign o_w_ppreg   = r_msg.ppreg;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_wb_arbiter                                                |
// | Purpose : Self-checking bench for wb_arbiter (4 units, default widths) |
// | Ports   : none                                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int c_NU = 4;

  logic                  clk;
  logic                  rst;
  logic [c_NU-1:0]       x_val;
  logic [c_NU-1:0]       x_rdy;
  logic [c_NU-1:0][31:0] x_pc;
  logic [c_NU-1:0][4:0]  x_seq_num;
  logic [c_NU-1:0][4:0]  x_waddr;
  logic [c_NU-1:0][31:0] x_wdata;
  logic [c_NU-1:0]       x_wen;
  logic [c_NU-1:0][5:0]  x_preg;
  logic [c_NU-1:0][5:0]  x_ppreg;
  logic                  w_val;
  logic                  w_rdy;
  logic [31:0]           w_pc;
  logic [4:0]            w_seq_num;
  logic [4:0]            w_waddr;
  logic [31:0]           w_wdata;
  logic                  w_wen;
  logic [5:0]            w_preg;
  logic [5:0]            w_ppreg;
  logic [1:0]            w_unit;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.NUM_UNITS(4), .SEQ_NUM_BITS(5), .PHYS_ADDR_BITS(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_x_val     (x_val),
    .o_x_rdy     (x_rdy),
    .i_x_pc      (x_pc),
    .i_x_seq_num (x_seq_num),
    .i_x_waddr   (x_waddr),
    .i_x_wdata   (x_wdata),
    .i_x_wen     (x_wen),
    .i_x_preg    (x_preg),
    .i_x_ppreg   (x_ppreg),
    .o_w_val     (w_val),
    .i_w_rdy     (w_rdy),
    .o_w_pc      (w_pc),
    .o_w_seq_num (w_seq_num),
    .o_w_waddr   (w_waddr),
    .o_w_wdata   (w_wdata),
    .o_w_wen     (w_wen),
    .o_w_preg    (w_preg),
    .o_w_ppreg   (w_ppreg),
    .o_w_unit    (w_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-unit payload: fixed fields depend on the unit, wdata carries the row tag.
  function automatic logic [54:0] side_fields(input int u);
    logic [31:0] pc;
    logic [4:0]  sq;
    logic [4:0]  wa;
    logic        we;
    logic [5:0]  pr;
    logic [5:0]  pp;
    pc = 32'h1000 + 32'(u) * 4;
    sq = 5'(u + 1);
    wa = 5'(u + 8);
    we = (u % 2) == 1;
    pr = 6'(u + 20);
    pp = 6'(u + 40);
    return {pc, sq, wa, we, pr, pp};
  endfunction

  task automatic drive_units(input int row);
    for (int i = 0; i < c_NU; i++) begin
      {x_pc[i], x_seq_num[i], x_waddr[i], x_wen[i], x_preg[i], x_ppreg[i]} = side_fields(i);
      x_wdata[i] = {16'(row), 16'(i)};
    end
  endtask

  typedef struct {
    logic [3:0] xv;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_wv;
    int         exp_unit;
    int         exp_row;
  } vec_t;

  vec_t vt[18];

  initial begin
    int grants;
    int waited;
    bool_dummy: begin end
    rst = 1'b1; x_val = '0; w_rdy = 1'b0;
    drive_units(0);
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_w_val", 64'(w_val), 64'(0));
    chk("reset_w_wdata", 64'(w_wdata), 64'(0));
    chk("reset_w_unit", 64'(w_unit), 64'(0));
    chk("reset_x_rdy", 64'(x_rdy), 64'(0));
    rst = 1'b0;

    // Round robin, wrap, drain, backpressure, drain+refill, rotation
    vt[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 0};
    vt[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1};
    vt[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 2};
    vt[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 3};
    vt[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 4};
    vt[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 4};
    vt[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0, 6};
    vt[7]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 0, 6};
    vt[8]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 0, 6};
    vt[9]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 0, 6};
    vt[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1, 10};
    vt[11] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3, 11};
    vt[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0, 12};
    vt[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 0, 12};
    vt[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 12};
    vt[15] = '{4'b0101, 1'b0, 4'b0100, 1'b1, 2, 15};
    vt[16] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 0, 16};
    vt[17] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2, 17};

    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      x_val = vt[r].xv;
      w_rdy = vt[r].rdy;
      drive_units(r);
      #1;
      chk($sformatf("v%0d_x_rdy", r), 64'(x_rdy), 64'(vt[r].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_w_val", r), 64'(w_val), 64'(vt[r].exp_wv));
      chk($sformatf("v%0d_w_unit", r), 64'(w_unit), 64'(vt[r].exp_unit));
      chk($sformatf("v%0d_w_wdata", r), 64'(w_wdata),
          64'({16'(vt[r].exp_row), 16'(vt[r].exp_unit)}));
      chk($sformatf("v%0d_w_fields", r),
          64'({w_pc, w_seq_num, w_waddr, w_wen, w_preg, w_ppreg}),
          64'(side_fields(vt[r].exp_unit)));
    end

    // Asynchronous reset mid-cycle while w_val=1 (pointer is 3 here)
    @(negedge clk);
    x_val = '0; w_rdy = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_w_val", 64'(w_val), 64'(0));
    chk("async_rst_w_wdata", 64'(w_wdata), 64'(0));
    chk("async_rst_x_rdy", 64'(x_rdy), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    x_val = 4'b1111;
    #1;
    chk("rst_ptr_zero_grant", 64'(x_rdy), 64'(4'b0001));
    x_val = '0;

    // Single requester: unit 2
    @(negedge clk);
    x_wdata[2] = 32'hDEADBEEF; x_seq_num[2] = 5'h05; x_waddr[2] = 5'd3;
    x_val = 4'b0100; w_rdy = 1'b1;
    #1;
    chk("single_x_rdy", 64'(x_rdy), 64'(4'b0100));
    @(posedge clk);
    #1;
    chk("single_w_val", 64'(w_val), 64'(1));
    chk("single_w_unit", 64'(w_unit), 64'(2));
    chk("single_w_wdata", 64'(w_wdata), 64'(32'hDEADBEEF));
    chk("single_w_seq", 64'(w_seq_num), 64'(5'h05));
    chk("single_w_waddr", 64'(w_waddr), 64'(3));
    @(negedge clk);
    x_val = '0;
    @(posedge clk);
    #1;
    chk("single_drain_w_val", 64'(w_val), 64'(0));
    chk("single_hold_wdata", 64'(w_wdata), 64'(32'hDEADBEEF));

    // Starvation: unit 0 always valid, unit 3 joins after 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      x_val = 4'b0001; w_rdy = 1'b1;
      #1;
      chk($sformatf("starve_u0_c%0d", c), 64'(x_rdy), 64'(4'b0001));
    end
    @(negedge clk);
    x_val = 4'b1001;
    grants = 0;
    waited = 0;
    while (waited < 8) begin
      #1;
      if (x_rdy != 4'b0000) grants++;
      if (x_rdy[3]) break;
      @(negedge clk);
      waited++;
    end
    chk("starve_u3_granted", 64'(x_rdy[3]), 64'(1));
    chk("starve_u3_within4", 64'(grants <= 4), 64'(1));
    x_val = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
